// File: rtl/wire_pipe_pkg.sv
// Shared constants and helpers for the wire_pipe elastic retiming pipeline.
package wire_pipe_pkg;

    // Deepest pipeline a lane is intended to be built with.
    localparam int unsigned MAX_STAGES = 16;

    // Width of a per-lane occupancy count; a zero-stage lane still gets one
    // bit so the packed occupancy bus never collapses to zero width.
    function automatic int unsigned occ_width(input int unsigned stages);
        return (stages == 0) ? 1 : $clog2(stages + 1);
    endfunction

    // Bit offset of lane k inside a packed CHANNELS*width bus.
    function automatic int unsigned lane_slice(input int unsigned k, input int unsigned width);
        return k * width;
    endfunction

endpackage

// File: rtl/wire_pipe_lane.sv
// One lane of wire_pipe: a STAGES-deep valid/ready register pipeline with a
// combinational ready chain and no skid buffer. STAGES=0 is a plain wire.
// Optional macro WIRE_PIPE_OCCUPANCY_EN adds a registered per-lane count of
// valid stages.
module wire_pipe_lane
    import wire_pipe_pkg::*;
#(
    parameter int unsigned WIDTH  = 1,
    parameter int unsigned STAGES = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out
`ifdef WIRE_PIPE_OCCUPANCY_EN
    ,
    output logic [occ_width(STAGES)-1:0] occupancy
`endif
);

    localparam int unsigned OW = occ_width(STAGES);

    generate
        if (STAGES == 0) begin : g_wire
            // Pure combinational pass-through; flush blocks the handshake both ways.
            assign out       = in;
            assign out_valid = in_valid && !flush;
            assign in_ready  = out_ready && !flush;
`ifdef WIRE_PIPE_OCCUPANCY_EN
            assign occupancy = '0;
`endif
        end else begin : g_pipe
            logic [STAGES-1:0] v_q;
            logic [STAGES-1:0] v_d;
            logic [WIDTH-1:0]  d_q [STAGES];
            logic [WIDTH-1:0]  d_d [STAGES];
            logic [STAGES:0]   rdy;
            logic              push;

            // Ready chain: a stage can load when it is empty or its successor loads.
            always_comb begin
                rdy         = '0;
                rdy[STAGES] = out_ready;
                for (int s = STAGES - 1; s >= 0; s--) begin
                    rdy[s] = !v_q[s] || rdy[s+1];
                end
            end

            assign in_ready  = rdy[0] && !flush;
            assign push      = in_valid && in_ready;
            assign out_valid = v_q[STAGES-1];
            assign out       = d_q[STAGES-1];

            // Next-state: shift forward where enabled; bubbles keep old data.
            always_comb begin
                v_d = v_q;
                d_d = d_q;
                if (rdy[0]) begin
                    v_d[0] = push;
                    if (push) begin
                        d_d[0] = in;
                    end
                end
                for (int s = 1; s < STAGES; s++) begin
                    if (rdy[s]) begin
                        v_d[s] = v_q[s-1];
                        if (v_q[s-1]) begin
                            d_d[s] = d_q[s-1];
                        end
                    end
                end
                // Flush empties the pipe but deliberately leaves data registers alone.
                if (flush) begin
                    v_d = '0;
                end
            end

            // Stage valid and data registers.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v_q <= '0;
                    for (int s = 0; s < STAGES; s++) begin
                        d_q[s] <= '0;
                    end
                end else begin
                    v_q <= v_d;
                    for (int s = 0; s < STAGES; s++) begin
                        d_q[s] <= d_d[s];
                    end
                end
            end

`ifdef WIRE_PIPE_OCCUPANCY_EN
            logic [OW-1:0] occ_q;
            logic [OW-1:0] occ_d;
            logic          pop;

            assign pop       = v_q[STAGES-1] && out_ready;
            assign occupancy = occ_q;

            // Occupancy next-state: push and pop together leave the count unchanged.
            always_comb begin
                occ_d = occ_q;
                if (flush) begin
                    occ_d = '0;
                end else if (push && !pop) begin
                    occ_d = occ_q + 1'b1;
                end else if (pop && !push) begin
                    occ_d = occ_q - 1'b1;
                end
            end

            // Occupancy register.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    occ_q <= '0;
                end else begin
                    occ_q <= occ_d;
                end
            end

            // The count must always agree with the number of valid stages.
            always @(posedge clk) begin
                if (rst_n) begin
                    assert (occ_q == OW'($countones(v_q)))
                        else $error("wire_pipe_lane occupancy %0d disagrees with valid stages", occ_q);
                end
            end
`endif
        end
    endgenerate

endmodule

// File: rtl/wire_pipe.sv
// wire_pipe top: CHANNELS independent elastic lanes of WIDTH bits, each
// STAGES registers deep, sharing only clk, rst_n and flush.
// Optional macro WIRE_PIPE_OCCUPANCY_EN adds the packed occupancy output.
module wire_pipe
    import wire_pipe_pkg::*;
#(
    parameter int unsigned WIDTH    = 1,
    parameter int unsigned CHANNELS = 1,
    parameter int unsigned STAGES   = 2
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  flush,
    input  logic [CHANNELS-1:0]                   in_valid,
    output logic [CHANNELS-1:0]                   in_ready,
    input  logic [CHANNELS*WIDTH-1:0]             in,
    output logic [CHANNELS-1:0]                   out_valid,
    input  logic [CHANNELS-1:0]                   out_ready,
    output logic [CHANNELS*WIDTH-1:0]             out
`ifdef WIRE_PIPE_OCCUPANCY_EN
    ,
    output logic [CHANNELS*occ_width(STAGES)-1:0] occupancy
`endif
);

    localparam int unsigned OW = occ_width(STAGES);

    // One lane instance per channel; buses are sliced by lane offset.
    for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
        wire_pipe_lane #(
            .WIDTH  (WIDTH),
            .STAGES (STAGES)
        ) u_lane (
            .clk       (clk),
            .rst_n     (rst_n),
            .flush     (flush),
            .in_valid  (in_valid[k]),
            .in_ready  (in_ready[k]),
            .in        (in[lane_slice(k, WIDTH) +: WIDTH]),
            .out_valid (out_valid[k]),
            .out_ready (out_ready[k]),
            .out       (out[lane_slice(k, WIDTH) +: WIDTH])
`ifdef WIRE_PIPE_OCCUPANCY_EN
            ,
            .occupancy (occupancy[lane_slice(k, OW) +: OW])
`endif
        );
    end

endmodule

// File: tb/tb_wire_pipe.sv
// Directed self-checking bench for wire_pipe with hand-computed expectations.
module tb_wire_pipe;
    import wire_pipe_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    // A: WIDTH=8, CHANNELS=2, STAGES=2
    logic        a_flush = 1'b0;
    logic [1:0]  a_in_valid = '0, a_in_ready, a_out_valid, a_out_ready = 2'b11;
    logic [15:0] a_in = '0, a_out;
    logic [2*occ_width(2)-1:0] a_occ;
    // B: WIDTH=8, CHANNELS=1, STAGES=3
    logic        b_flush = 1'b0, b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b0;
    logic [7:0]  b_in = '0, b_out;
    logic [occ_width(3)-1:0] b_occ;
    // C: WIDTH=8, CHANNELS=1, STAGES=0
    logic        c_flush = 1'b0, c_in_valid = 1'b0, c_in_ready, c_out_valid, c_out_ready = 1'b0;
    logic [7:0]  c_in = '0, c_out;
    logic [occ_width(0)-1:0] c_occ;

    wire_pipe #(.WIDTH(8), .CHANNELS(2), .STAGES(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .flush(a_flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in(a_in),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out(a_out)
`ifdef WIRE_PIPE_OCCUPANCY_EN
        , .occupancy(a_occ)
`endif
    );

    wire_pipe #(.WIDTH(8), .CHANNELS(1), .STAGES(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in(b_in),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out(b_out)
`ifdef WIRE_PIPE_OCCUPANCY_EN
        , .occupancy(b_occ)
`endif
    );

    wire_pipe #(.WIDTH(8), .CHANNELS(1), .STAGES(0)) dut_c (
        .clk(clk), .rst_n(rst_n), .flush(c_flush),
        .in_valid(c_in_valid), .in_ready(c_in_ready), .in(c_in),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .out(c_out)
`ifdef WIRE_PIPE_OCCUPANCY_EN
        , .occupancy(c_occ)
`endif
    );

`ifdef WIRE_PIPE_OCCUPANCY_EN
    // D: WIDTH=8, CHANNELS=1, STAGES=4, only meaningful with the count present
    logic        d_flush = 1'b0, d_in_valid = 1'b0, d_in_ready, d_out_valid, d_out_ready = 1'b0;
    logic [7:0]  d_in = '0, d_out;
    logic [occ_width(4)-1:0] d_occ;

    wire_pipe #(.WIDTH(8), .CHANNELS(1), .STAGES(4)) dut_d (
        .clk(clk), .rst_n(rst_n), .flush(d_flush),
        .in_valid(d_in_valid), .in_ready(d_in_ready), .in(d_in),
        .out_valid(d_out_valid), .out_ready(d_out_ready), .out(d_out),
        .occupancy(d_occ)
    );
`endif

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state and mid-stream reset on A
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 32'(a_in_ready), 32'h3);
        chk("rst_out_valid", 32'(a_out_valid), 32'h0);
        chk("rst_out", 32'(a_out), 32'h0);
        chk("rst_b_in_ready", 32'(b_in_ready), 32'h1);
        a_in_valid = 2'b01;
        a_in       = 16'h00A5;
        step();
        a_in_valid = 2'b00;
        rst_n      = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(a_out_valid), 32'h0);
        chk("midrst_out", 32'(a_out), 32'h0);
        step();
        step();
        rst_n = 1'b1;
        #1;
        chk("postrst_in_ready", 32'(a_in_ready), 32'h3);
        for (int i = 0; i < 4; i++) begin
            step();
            #1;
            chk("a5_never_out", 32'(a_out_valid), 32'h0);
        end
        step();

        // Latency 2 and full throughput on lane 0
        for (int i = 0; i < 18; i++) begin
            a_in_valid[0] = (i < 16);
            a_in[7:0]     = 8'(i + 1);
            #1;
            chk("tput_in_ready", 32'(a_in_ready[0]), 32'h1);
            chk("lat_out_valid", 32'(a_out_valid[0]), (i >= 2) ? 32'h1 : 32'h0);
            if (i >= 2) chk("tput_data", 32'(a_out[7:0]), 32'(i - 1));
            step();
        end
        a_in_valid = 2'b00;

        // Lane isolation: lane 1 stalled holding 0x3C while lane 0 streams
        a_out_ready = 2'b01;
        for (int i = 0; i < 8; i++) begin
            a_in_valid = {(i == 0), 1'b1};
            a_in       = {8'h3C, 8'(8'h40 + i)};
            #1;
            chk("iso_l0_ready", 32'(a_in_ready[0]), 32'h1);
            chk("iso_l0_valid", 32'(a_out_valid[0]), (i >= 2) ? 32'h1 : 32'h0);
            if (i >= 2) begin
                chk("iso_l0_data", 32'(a_out[7:0]), 32'(8'h40 + i - 2));
                chk("iso_l1_valid", 32'(a_out_valid[1]), 32'h1);
                chk("iso_l1_data", 32'(a_out[15:8]), 32'h3C);
            end
            step();
        end
        a_in_valid  = 2'b00;
        a_out_ready = 2'b11;
        repeat (3) step();

        // Back-pressure on B (STAGES=3): three accepted, fourth held
        for (int j = 0; j < 5; j++) begin
            b_in_valid = 1'b1;
            b_in       = 8'(8'h11 + ((j < 3) ? j : 3));
            #1;
            chk("bp_in_ready", 32'(b_in_ready), (j < 3) ? 32'h1 : 32'h0);
            chk("bp_out_valid", 32'(b_out_valid), (j >= 3) ? 32'h1 : 32'h0);
            if (j >= 3) chk("bp_hold_data", 32'(b_out), 32'h11);
            step();
        end
        b_out_ready = 1'b1;
        #1;
        chk("bp_pushpop_ready", 32'(b_in_ready), 32'h1);
        chk("bp_pushpop_data", 32'(b_out), 32'h11);
        step();
        b_in_valid = 1'b0;
        for (int j = 0; j < 3; j++) begin
            #1;
            chk("bp_drain_valid", 32'(b_out_valid), 32'h1);
            chk("bp_drain_data", 32'(b_out), 32'(8'h12 + j));
            step();
        end
        #1;
        chk("bp_empty", 32'(b_out_valid), 32'h0);
        step();

        // Flush of a full B pipeline
        b_out_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            b_in_valid = 1'b1;
            b_in       = 8'(8'h21 + j);
            step();
        end
        b_in    = 8'h99;
        b_flush = 1'b1;
        #1;
        chk("fl_in_ready", 32'(b_in_ready), 32'h0);
        chk("fl_out_valid_during", 32'(b_out_valid), 32'h1);
        step();
        b_flush    = 1'b0;
        b_in_valid = 1'b0;
        #1;
        chk("fl_out_valid_after", 32'(b_out_valid), 32'h0);
        chk("fl_data_kept", 32'(b_out), 32'h21);
        chk("fl_in_ready_after", 32'(b_in_ready), 32'h1);
        b_out_ready = 1'b1;
        b_in_valid  = 1'b1;
        b_in        = 8'h77;
        step();
        b_in_valid = 1'b0;
        for (int j = 1; j < 5; j++) begin
            #1;
            chk("fl_77_valid", 32'(b_out_valid), (j == 3) ? 32'h1 : 32'h0);
            if (j == 3) chk("fl_77_data", 32'(b_out), 32'h77);
            step();
        end

        // STAGES=0 wire mode, no clock edge relied upon
        c_in = 8'h5A; c_in_valid = 1'b1; c_out_ready = 1'b1;
        #1;
        chk("w_out", 32'(c_out), 32'h5A);
        chk("w_valid", 32'(c_out_valid), 32'h1);
        chk("w_ready", 32'(c_in_ready), 32'h1);
        c_in = 8'hC3; c_in_valid = 1'b0;
        #1;
        chk("w_out2", 32'(c_out), 32'hC3);
        chk("w_valid2", 32'(c_out_valid), 32'h0);
        c_out_ready = 1'b0;
        #1;
        chk("w_ready2", 32'(c_in_ready), 32'h0);
        c_in_valid = 1'b1; c_out_ready = 1'b1; c_flush = 1'b1;
        #1;
        chk("w_flush_valid", 32'(c_out_valid), 32'h0);
        chk("w_flush_ready", 32'(c_in_ready), 32'h0);
        c_flush = 1'b0;

`ifdef WIRE_PIPE_OCCUPANCY_EN
        step();
        #1;
        chk("occ_init", 32'(d_occ), 32'h0);
        for (int j = 0; j < 4; j++) begin
            d_in_valid = 1'b1;
            d_in       = 8'(j);
            step();
            #1;
            chk("occ_step", 32'(d_occ), 32'(j + 1));
        end
        d_in_valid = 1'b0;
        d_flush    = 1'b1;
        step();
        d_flush = 1'b0;
        #1;
        chk("occ_flush", 32'(d_occ), 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
